// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter: writeback primary, one-entry buffered secondary, optional clear.
// Define IBEX_RF_CLEAR_EN to clear words 1..NumWords-1 to WordZeroVal after reset.
module ibex_rf_wport_arbiter #(
   parameter int unsigned          NumWords    = 32,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0,
   parameter int unsigned          MaxStall    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wb_req_i,
   input  logic [4:0]           wb_waddr_i,
   input  logic [DataWidth-1:0] wb_wdata_i,
   output logic                 wb_gnt_o,
   input  logic                 sec_valid_i,
   input  logic [4:0]           sec_waddr_i,
   input  logic [DataWidth-1:0] sec_wdata_i,
   output logic                 sec_ready_o,
   output logic                 sec_drop_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 init_done_o
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   localparam logic [4:0] LastAddr = 5'(NumWords - 1);
   localparam logic [3:0] StallMax = 4'(MaxStall);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_buf_valid;
   logic [4:0]             r_buf_addr;
   logic [DataWidth-1:0]   r_buf_data;
   logic [3:0]             r_stall_cnt;

   logic                   w_clr_last;
   logic [4:0]             w_clr_addr;
   logic                   w_run;
   logic                   w_force;
   logic                   w_wb_fire;
   logic                   w_wb_we;
   logic                   w_sec_fire;
   logic                   w_drain;
   logic                   w_drop;

`ifdef IBEX_RF_CLEAR_EN
   localparam state_e ResetState = ST_INIT;
   logic [4:0] r_clr_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_clr_cnt <= 5'd1;
      else if (r_state == ST_INIT)
         r_clr_cnt <= r_clr_cnt + 5'd1;
   end

   assign w_clr_addr = r_clr_cnt;
   assign w_clr_last = (r_clr_cnt == LastAddr);
`else
   localparam state_e ResetState = ST_RUN;
   assign w_clr_addr = LastAddr;
   assign w_clr_last = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= ResetState;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && w_clr_last)
         w_state_nxt = ST_RUN;
   end

   // Reset gates every handshake so nothing is accepted or written while rst_i is high.
   assign w_run       = !rst_i && (r_state == ST_RUN);
   assign w_force     = r_buf_valid && (r_stall_cnt == StallMax);
   assign wb_gnt_o    = w_run && !w_force;
   assign w_wb_fire   = wb_req_i && wb_gnt_o;
   assign w_wb_we     = w_wb_fire && (wb_waddr_i != 5'd0);
   assign sec_ready_o = w_run && !r_buf_valid;
   assign w_sec_fire  = sec_valid_i && sec_ready_o;
   assign w_drain     = w_run && r_buf_valid && (w_force || !w_wb_fire);
   // A younger primary write to the buffered address makes the buffered data stale.
   assign w_drop      = w_wb_we && r_buf_valid && (wb_waddr_i == r_buf_addr);
   assign sec_drop_o  = w_drop;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_buf_valid <= 1'b0;
      else if (w_sec_fire)
         r_buf_valid <= (sec_waddr_i != 5'd0);
      else if (w_drain || w_drop)
         r_buf_valid <= 1'b0;
   end

   // NOTE: the buffer payload has no reset; r_buf_valid alone qualifies it.
   always_ff @(posedge clk_i) begin
      if (w_sec_fire) begin
         r_buf_addr <= sec_waddr_i;
         r_buf_data <= sec_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_stall_cnt <= 4'd0;
      else if (w_drain || w_drop)
         r_stall_cnt <= 4'd0;
      else if (r_buf_valid && r_stall_cnt != StallMax)
         r_stall_cnt <= r_stall_cnt + 4'd1;
   end

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      rf_we_o     = 1'b0;
      rf_waddr_o  = wb_waddr_i;
      rf_wdata_o  = wb_wdata_i;
      init_done_o = 1'b0;
      if (!rst_i) begin
         unique case (r_state)
            ST_INIT: begin
               rf_we_o    = 1'b1;
               rf_waddr_o = w_clr_addr;
               rf_wdata_o = WordZeroVal;
            end
            ST_RUN: begin
               init_done_o = 1'b1;
               if (w_drain) begin
                  rf_we_o    = 1'b1;
                  rf_waddr_o = r_buf_addr;
                  rf_wdata_o = r_buf_data;
               end else if (w_wb_we) begin
                  rf_we_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Self-checking bench for ibex_rf_wport_arbiter: per-cycle vector table plus an RF-write scoreboard.
// Clear-sequence checks are compiled in when IBEX_RF_CLEAR_EN is defined.
module tb_ibex_rf_wport_arbiter;

   localparam int          DW = 32;
   localparam logic [31:0] ZV = 32'h0BAD_F00D;
   localparam int          NV = 20;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        wb_req;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        sec_valid;
      logic [4:0]  sec_addr;
      logic [31:0] sec_data;
      logic        e_gnt;
      logic        e_ready;
      logic        e_we;
      logic        e_drop;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
   } vec_t;

   logic          clk;
   logic          rst_i;
   logic          wb_req_i;
   logic [4:0]    wb_waddr_i;
   logic [DW-1:0] wb_wdata_i;
   logic          wb_gnt_o;
   logic          sec_valid_i;
   logic [4:0]    sec_waddr_i;
   logic [DW-1:0] sec_wdata_i;
   logic          sec_ready_o;
   logic          sec_drop_o;
   logic          rf_we_o;
   logic [4:0]    rf_waddr_o;
   logic [DW-1:0] rf_wdata_o;
   logic          init_done_o;

   int   n_checks;
   int   n_errors;
   wr_t  sb_q[$];
   wr_t  mon_e;
   vec_t vecs[NV];

   ibex_rf_wport_arbiter #(
      .NumWords   (32),
      .DataWidth  (DW),
      .WordZeroVal(ZV),
      .MaxStall   (4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .wb_req_i   (wb_req_i),
      .wb_waddr_i (wb_waddr_i),
      .wb_wdata_i (wb_wdata_i),
      .wb_gnt_o   (wb_gnt_o),
      .sec_valid_i(sec_valid_i),
      .sec_waddr_i(sec_waddr_i),
      .sec_wdata_i(sec_wdata_i),
      .sec_ready_o(sec_ready_o),
      .sec_drop_o (sec_drop_o),
      .rf_we_o    (rf_we_o),
      .rf_waddr_o (rf_waddr_o),
      .rf_wdata_o (rf_wdata_o),
      .init_done_o(init_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit wr, input int wa, input int unsigned wd,
                               input bit sv, input int sa, input int unsigned sd,
                               input bit g, input bit r, input bit we, input bit dr,
                               input int ea, input int unsigned ed);
      vec_t v;
      v.wb_req    = wr;
      v.wb_addr   = 5'(wa);
      v.wb_data   = 32'(wd);
      v.sec_valid = sv;
      v.sec_addr  = 5'(sa);
      v.sec_data  = 32'(sd);
      v.e_gnt     = g;
      v.e_ready   = r;
      v.e_we      = we;
      v.e_drop    = dr;
      v.e_addr    = 5'(ea);
      v.e_data    = 32'(ed);
      return v;
   endfunction

   task automatic drive_idle();
      wb_req_i    = 1'b0;
      wb_waddr_i  = 5'd0;
      wb_wdata_i  = '0;
      sec_valid_i = 1'b0;
      sec_waddr_i = 5'd0;
      sec_wdata_i = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rf_we"},     rf_we_o,     1'b0);
      check({tag, "_gnt"},       wb_gnt_o,    1'b0);
      check({tag, "_ready"},     sec_ready_o, 1'b0);
      check({tag, "_drop"},      sec_drop_o,  1'b0);
      check({tag, "_init_done"}, init_done_o, 1'b0);
   endtask

   // Every RF write the DUT makes must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_we_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rf_unexpected: addr 0x%0h data 0x%0h with no write expected",
                     rf_waddr_o, rf_wdata_o);
         end else begin
            mon_e = sb_q.pop_front();
            check("rf_waddr", 32'(rf_waddr_o), 32'(mon_e.addr));
            check("rf_wdata", rf_wdata_o, mon_e.data);
         end
      end
   end

`ifdef IBEX_RF_CLEAR_EN
   // Walks the clear sequence; optionally raises reset in the cycle that writes stop_at.
   task automatic run_clear(input int stop_at);
      for (int a = 1; a < 32; a++) begin
         sb_q.push_back(wr_t'{addr: 5'(a), data: ZV});
         @(negedge clk);
         check("clr_we",        rf_we_o,     1'b1);
         check("clr_init_done", init_done_o, 1'b0);
         check("clr_gnt",       wb_gnt_o,    1'b0);
         check("clr_ready",     sec_ready_o, 1'b0);
         if (a == stop_at) begin
            #1 rst_i = 1'b1;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_errors = 0;

      // Primary write to 3 lands in the first RUN cycle.
      vecs[0]  = mk(1, 3,  'h1234, 0, 0,  0,     1, 1, 1, 0, 3,  'h1234);
      vecs[1]  = mk(0, 0,  0,      0, 0,  0,     1, 1, 0, 0, 0,  0);
      vecs[2]  = mk(1, 0,  'hDEAD, 0, 0,  0,     1, 1, 0, 0, 0,  0);
      // Secondary to 7 waits behind a stream of primary writes until forced.
      vecs[3]  = mk(1, 5,  'h100,  1, 7,  'hA5,  1, 1, 1, 0, 5,  'h100);
      vecs[4]  = mk(1, 5,  'h101,  0, 0,  0,     1, 0, 1, 0, 5,  'h101);
      vecs[5]  = mk(1, 5,  'h102,  0, 0,  0,     1, 0, 1, 0, 5,  'h102);
      vecs[6]  = mk(1, 5,  'h103,  0, 0,  0,     1, 0, 1, 0, 5,  'h103);
      vecs[7]  = mk(1, 5,  'h104,  0, 0,  0,     1, 0, 1, 0, 5,  'h104);
      vecs[8]  = mk(1, 5,  'h105,  0, 0,  0,     0, 0, 1, 0, 7,  'hA5);
      vecs[9]  = mk(1, 5,  'h105,  0, 0,  0,     1, 1, 1, 0, 5,  'h105);
      // Buffered write to 9 superseded by a primary write to 9.
      vecs[10] = mk(0, 0,  0,      1, 9,  'h99,  1, 1, 0, 0, 0,  0);
      vecs[11] = mk(1, 9,  'h11,   0, 0,  0,     1, 0, 1, 1, 9,  'h11);
      vecs[12] = mk(0, 0,  0,      0, 0,  0,     1, 1, 0, 0, 0,  0);
      // Secondary to address 0 is accepted and discarded.
      vecs[13] = mk(0, 0,  0,      1, 0,  'h55,  1, 1, 0, 0, 0,  0);
      vecs[14] = mk(0, 0,  0,      0, 0,  0,     1, 1, 0, 0, 0,  0);
      // Idle port drains the buffer in the cycle after the handshake.
      vecs[15] = mk(0, 0,  0,      1, 12, 'h77,  1, 1, 0, 0, 0,  0);
      vecs[16] = mk(0, 0,  0,      0, 0,  0,     1, 0, 1, 0, 12, 'h77);
      // Same-cycle primary and secondary to 13: primary first, secondary lands after.
      vecs[17] = mk(1, 13, 'h30,   1, 13, 'h31,  1, 1, 1, 0, 13, 'h30);
      vecs[18] = mk(0, 0,  0,      0, 0,  0,     1, 0, 1, 0, 13, 'h31);
      vecs[19] = mk(0, 0,  0,      0, 0,  0,     1, 1, 0, 0, 0,  0);

      rst_i = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #1;
      rst_i = 1'b0;

`ifdef IBEX_RF_CLEAR_EN
      run_clear(12);
      @(negedge clk);
      check_reset_outputs("rst_mid_clear");
      @(posedge clk); #1;
      rst_i = 1'b0;
      run_clear(0);
`endif

      for (int i = 0; i < NV; i++) begin
         wb_req_i    = vecs[i].wb_req;
         wb_waddr_i  = vecs[i].wb_addr;
         wb_wdata_i  = vecs[i].wb_data;
         sec_valid_i = vecs[i].sec_valid;
         sec_waddr_i = vecs[i].sec_addr;
         sec_wdata_i = vecs[i].sec_data;
         if (vecs[i].e_we)
            sb_q.push_back(wr_t'{addr: vecs[i].e_addr, data: vecs[i].e_data});
         @(negedge clk);
         check($sformatf("v%0d_gnt", i),       wb_gnt_o,    vecs[i].e_gnt);
         check($sformatf("v%0d_ready", i),     sec_ready_o, vecs[i].e_ready);
         check($sformatf("v%0d_we", i),        rf_we_o,     vecs[i].e_we);
         check($sformatf("v%0d_drop", i),      sec_drop_o,  vecs[i].e_drop);
         check($sformatf("v%0d_init_done", i), init_done_o, 1'b1);
         @(posedge clk); #1;
      end

      // Reset while a secondary write sits in the buffer: it must be abandoned.
      drive_idle();
      sec_valid_i = 1'b1;
      sec_waddr_i = 5'd20;
      sec_wdata_i = 32'hCC;
      @(negedge clk);
      check("buf_load_ready", sec_ready_o, 1'b1);
      check("buf_load_we",    rf_we_o,     1'b0);
      @(posedge clk); #1;
      drive_idle();
      rst_i      = 1'b1;
      wb_req_i   = 1'b1;
      wb_waddr_i = 5'd21;
      wb_wdata_i = 32'hEE;
      @(negedge clk);
      check_reset_outputs("rst_buf");
      @(posedge clk); #1;
      rst_i = 1'b0;
      drive_idle();
`ifdef IBEX_RF_CLEAR_EN
      run_clear(0);
`endif
      @(negedge clk);
      check("post_rst_ready",     sec_ready_o, 1'b1);
      check("post_rst_we",        rf_we_o,     1'b0);
      check("post_rst_init_done", init_done_o, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_idle_we", rf_we_o, 1'b0);
      @(posedge clk); #1;

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
